// File: rtl/r5p_tcb_htif.sv
// ----------------------------------------------------------------------------
// r5p_tcb_htif
//
// Host-target interface peripheral on one TCB port. It captures the test exit
// write to TOHOST, holds the signature bounds, counts cycles and runs a
// watchdog. The done/pass/exit_code/timeout outputs let a bench or an FPGA
// build end a test without a behavioural monitor.
//
// Register map (byte offsets, word access only):
//   0x00 TOHOST    W   bit0=1: exit with code wdt[31:1]; bit0=0: syscall,
//                      wdt is echoed into FROMHOST. Reads return 0.
//   0x04 FROMHOST  RW
//   0x08 SIG_BEGIN RW
//   0x0C SIG_END   RW
//   0x10 CYCLE     RO  free-running cycle counter (write is an error)
//   0x14 WDOG      RW  remaining cycles before timeout
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   tcb_vld    request valid
//   tcb_wen    write enable
//   tcb_adr    byte address offset [ADR_W-1:0]
//   tcb_siz    log2 transfer size (2 = word)
//   tcb_wdt    write data
//   tcb_rdt    read data, one cycle after the transfer
//   tcb_err    response error, one cycle after the transfer
//   tcb_rdy    request ready (high whenever reset is released)
//   done       test finished (exit or timeout)
//   pass       exit code zero and no timeout
//   exit_code  tohost[31:1] of the exit write
//   timeout    watchdog expired
// ----------------------------------------------------------------------------
module r5p_tcb_htif #(
    parameter int unsigned TIMEOUT = 20000,
    parameter int unsigned ADR_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tcb_vld,
    input  logic             tcb_wen,
    input  logic [ADR_W-1:0] tcb_adr,
    input  logic [1:0]       tcb_siz,
    input  logic [31:0]      tcb_wdt,
    output logic [31:0]      tcb_rdt,
    output logic             tcb_err,
    output logic             tcb_rdy,
    output logic             done,
    output logic             pass,
    output logic [30:0]      exit_code,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_EXIT = 2'd1,
        ST_TMO  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fromhost;
    logic [31:0] r_sig_begin;
    logic [31:0] r_sig_end;
    logic [31:0] r_cycle;
    logic [31:0] r_wdog;
    logic [31:0] r_rdt;
    logic        r_err;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout;
    logic [30:0] r_exit_code;

    logic        w_trn;
    logic [31:0] w_adr32;
    logic        w_sel_tohost;
    logic        w_sel_fromhost;
    logic        w_sel_sig_begin;
    logic        w_sel_sig_end;
    logic        w_sel_cycle;
    logic        w_sel_wdog;
    logic        w_word;
    logic        w_legal;
    logic        w_wr;
    logic        w_exit;
    logic        w_syscall;
    logic [31:0] w_wdog_next;
    logic [31:0] w_rd_data;

    // Ready tracks the reset input directly so a request can be accepted on
    // the very first edge after release.
    assign tcb_rdy = rst_n;
    assign w_trn   = tcb_vld & tcb_rdy;

    assign w_adr32         = 32'(tcb_adr);
    assign w_sel_tohost    = (w_adr32 == 32'h00);
    assign w_sel_fromhost  = (w_adr32 == 32'h04);
    assign w_sel_sig_begin = (w_adr32 == 32'h08);
    assign w_sel_sig_end   = (w_adr32 == 32'h0C);
    assign w_sel_cycle     = (w_adr32 == 32'h10);
    assign w_sel_wdog      = (w_adr32 == 32'h14);

    // Aligned word access inside the map; CYCLE is read-only.
    assign w_word  = (tcb_siz == 2'd2) && (tcb_adr[1:0] == 2'b00) && (w_adr32 <= 32'h14);
    assign w_legal = w_word && !(tcb_wen && w_sel_cycle);

    // Writes only take effect while running; after exit/timeout they are
    // acknowledged without error but dropped.
    assign w_wr      = w_trn && w_legal && tcb_wen && (r_state == ST_RUN);
    assign w_exit    = w_wr && w_sel_tohost && tcb_wdt[0];
    assign w_syscall = w_wr && w_sel_tohost && !tcb_wdt[0];

    // A write to WDOG overrides the decrement; the counter saturates at 0.
    always_comb begin
        w_wdog_next = r_wdog;
        if (w_wr && w_sel_wdog) begin
            w_wdog_next = tcb_wdt;
        end else if (r_wdog != 32'd0) begin
            w_wdog_next = r_wdog - 32'd1;
        end
    end

    always_comb begin
        w_rd_data = 32'd0;
        case (w_adr32)
            32'h04:  w_rd_data = r_fromhost;
            32'h08:  w_rd_data = r_sig_begin;
            32'h0C:  w_rd_data = r_sig_end;
            32'h10:  w_rd_data = r_cycle;
            32'h14:  w_rd_data = r_wdog;
            default: w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_fromhost  <= 32'd0;
            r_sig_begin <= 32'd0;
            r_sig_end   <= 32'd0;
            r_cycle     <= 32'd0;
            r_wdog      <= TIMEOUT;
            r_rdt       <= 32'd0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exit_code <= 31'd0;
        end else begin
            // Response is held until the next transfer replaces it.
            if (w_trn) begin
                r_rdt <= (w_legal && !tcb_wen) ? w_rd_data : 32'd0;
                r_err <= !w_legal;
            end

            case (r_state)
                ST_RUN: begin
                    r_cycle <= r_cycle + 32'd1;
                    r_wdog  <= w_wdog_next;

                    if ((w_wr && w_sel_fromhost) || w_syscall) r_fromhost <= tcb_wdt;
                    if (w_wr && w_sel_sig_begin)               r_sig_begin <= tcb_wdt;
                    if (w_wr && w_sel_sig_end)                 r_sig_end <= tcb_wdt;

                    // Exit takes priority over a watchdog expiring on the same edge.
                    if (w_exit) begin
                        r_state     <= ST_EXIT;
                        r_done      <= 1'b1;
                        r_pass      <= (tcb_wdt[31:1] == 31'd0);
                        r_exit_code <= tcb_wdt[31:1];
                    end else if (w_wdog_next == 32'd0) begin
                        r_state   <= ST_TMO;
                        r_done    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    // EXIT and TMO are terminal: counters and registers frozen.
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign tcb_rdt   = r_rdt;
    assign tcb_err   = r_err;
    assign done      = r_done;
    assign pass      = r_pass;
    assign exit_code = r_exit_code;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_r5p_tcb_htif.sv
module tb_r5p_tcb_htif;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tcb_vld = 1'b0;
    logic        tcb_wen = 1'b0;
    logic [4:0]  tcb_adr = 5'd0;
    logic [1:0]  tcb_siz = 2'd2;
    logic [31:0] tcb_wdt = 32'd0;
    logic [31:0] tcb_rdt;
    logic        tcb_err;
    logic        tcb_rdy;
    logic        done;
    logic        pass;
    logic [30:0] exit_code;
    logic        timeout;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0] rdt;
        logic        err;
        logic [4:0]  adr;
        logic        wen;
    } exp_t;

    exp_t sb[$];

    r5p_tcb_htif #(.TIMEOUT(TMO), .ADR_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tcb_vld   (tcb_vld),
        .tcb_wen   (tcb_wen),
        .tcb_adr   (tcb_adr),
        .tcb_siz   (tcb_siz),
        .tcb_wdt   (tcb_wdt),
        .tcb_rdt   (tcb_rdt),
        .tcb_err   (tcb_err),
        .tcb_rdy   (tcb_rdy),
        .done      (done),
        .pass      (pass),
        .exit_code (exit_code),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted transfer pops its expected response and
    // compares it on the following falling edge.
    always begin
        @(posedge clk);
        if (rst_n && tcb_vld && tcb_rdy) begin
            @(negedge clk);
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_underflow: transfer with no expected entry, rdt=%h err=%b", tcb_rdt, tcb_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("xfer adr=%h wen=%b rdt=%h err=%b (want rdt=%h err=%b)",
                         e.adr, e.wen, tcb_rdt, tcb_err, e.rdt, e.err);
                if (tcb_rdt !== e.rdt || tcb_err !== e.err)
                    $display("FAIL resp_adr%h: got rdt=%h err=%b want rdt=%h err=%b",
                             e.adr, tcb_rdt, tcb_err, e.rdt, e.err);
                else
                    n_pass++;
            end
        end
    end

    // Call at a falling edge; the transfer happens on the next rising edge and
    // the task returns on the falling edge after it.
    task automatic xfer(input logic w, input logic [4:0] a, input logic [1:0] s,
                        input logic [31:0] d, input logic [31:0] er, input logic ee);
        tcb_vld = 1'b1;
        tcb_wen = w;
        tcb_adr = a;
        tcb_siz = s;
        tcb_wdt = d;
        sb.push_back('{rdt: er, err: ee, adr: a, wen: w});
        @(negedge clk);
        tcb_vld = 1'b0;
        tcb_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        tcb_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Returns at the falling edge where reset is released.
    task automatic do_reset();
        tcb_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic arm();
        xfer(1'b1, 5'h14, 2'd2, 32'd1000, 32'd0, 1'b0);
    endtask

    task automatic test_reset();
        tcb_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tcb_rdy, done, pass, timeout, exit_code, tcb_rdt, tcb_err} !== 68'd0)
            $display("FAIL reset_outputs: got rdy=%b done=%b pass=%b tmo=%b code=%h rdt=%h err=%b want all 0",
                     tcb_rdy, done, pass, timeout, exit_code, tcb_rdt, tcb_err);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        // Edge 1 reads WDOG before the first decrement; CYCLE has counted 4 edges by edge 5.
        xfer(1'b0, 5'h14, 2'd2, 32'd0, TMO, 1'b0);
        xfer(1'b0, 5'h04, 2'd2, 32'd0, 32'd0, 1'b0);
        xfer(1'b0, 5'h08, 2'd2, 32'd0, 32'd0, 1'b0);
        xfer(1'b0, 5'h0C, 2'd2, 32'd0, 32'd0, 1'b0);
        xfer(1'b0, 5'h10, 2'd2, 32'd0, 32'd4, 1'b0);
        xfer(1'b0, 5'h14, 2'd2, 32'd0, TMO - 5, 1'b0);
    endtask

    task automatic test_regs();
        do_reset();
        arm();
        xfer(1'b1, 5'h08, 2'd2, 32'h8000_2000, 32'd0, 1'b0);
        xfer(1'b0, 5'h08, 2'd2, 32'd0, 32'h8000_2000, 1'b0);
        xfer(1'b1, 5'h08, 2'd0, 32'h0000_00FF, 32'd0, 1'b1);
        xfer(1'b1, 5'h10, 2'd2, 32'd5, 32'd0, 1'b1);
        xfer(1'b1, 5'h09, 2'd2, 32'h1111_1111, 32'd0, 1'b1);
        xfer(1'b0, 5'h18, 2'd2, 32'd0, 32'd0, 1'b1);
        xfer(1'b0, 5'h04, 2'd1, 32'd0, 32'd0, 1'b1);
        xfer(1'b0, 5'h08, 2'd2, 32'd0, 32'h8000_2000, 1'b0);
        xfer(1'b1, 5'h0C, 2'd2, 32'hDEAD_BEEF, 32'd0, 1'b0);
        xfer(1'b0, 5'h0C, 2'd2, 32'd0, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b1, 5'h04, 2'd2, 32'h1234_5678, 32'd0, 1'b0);
        xfer(1'b0, 5'h04, 2'd2, 32'd0, 32'h1234_5678, 1'b0);
        xfer(1'b1, 5'h14, 2'd2, 32'd500, 32'd0, 1'b0);
        xfer(1'b0, 5'h14, 2'd2, 32'd0, 32'd500, 1'b0);
        xfer(1'b0, 5'h00, 2'd2, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_syscall();
        do_reset();
        arm();
        xfer(1'b1, 5'h00, 2'd2, 32'h0000_0100, 32'd0, 1'b0);
        xfer(1'b0, 5'h04, 2'd2, 32'd0, 32'h0000_0100, 1'b0);
        n_checks++;
        if ({done, pass, timeout} !== 3'b000)
            $display("FAIL syscall_run: got done=%b pass=%b tmo=%b want 0 0 0", done, pass, timeout);
        else
            n_pass++;
    endtask

    task automatic test_exit_pass();
        do_reset();
        arm();
        xfer(1'b1, 5'h00, 2'd2, 32'h0000_0001, 32'd0, 1'b0);
        n_checks++;
        if ({done, pass, timeout, exit_code} !== {1'b1, 1'b1, 1'b0, 31'd0})
            $display("FAIL exit_pass_status: got done=%b pass=%b tmo=%b code=%h want 1 1 0 0",
                     done, pass, timeout, exit_code);
        else
            n_pass++;
        // Later writes are acknowledged but ignored.
        xfer(1'b1, 5'h00, 2'd2, 32'h0000_0007, 32'd0, 1'b0);
        xfer(1'b1, 5'h08, 2'd2, 32'h0000_0055, 32'd0, 1'b0);
        xfer(1'b0, 5'h08, 2'd2, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if ({done, pass, timeout, exit_code} !== {1'b1, 1'b1, 1'b0, 31'd0})
            $display("FAIL exit_pass_sticky: got done=%b pass=%b tmo=%b code=%h want 1 1 0 0",
                     done, pass, timeout, exit_code);
        else
            n_pass++;
    endtask

    task automatic test_exit_fail();
        do_reset();
        arm();
        xfer(1'b1, 5'h00, 2'd2, 32'h0000_0007, 32'd0, 1'b0);
        n_checks++;
        if ({done, pass, timeout, exit_code} !== {1'b1, 1'b0, 1'b0, 31'd3})
            $display("FAIL exit_fail_status: got done=%b pass=%b tmo=%b code=%h want 1 0 0 3",
                     done, pass, timeout, exit_code);
        else
            n_pass++;
    endtask

    task automatic test_timeout();
        int hit;
        hit = -1;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                hit = i;
                break;
            end
        end
        n_checks++;
        if (hit != int'(TMO))
            $display("FAIL timeout_cycle: got edge %0d want %0d (-1 = never)", hit, TMO);
        else
            n_pass++;
        n_checks++;
        if ({done, pass, timeout, exit_code} !== {1'b1, 1'b0, 1'b1, 31'd0})
            $display("FAIL timeout_status: got done=%b pass=%b tmo=%b code=%h want 1 0 1 0",
                     done, pass, timeout, exit_code);
        else
            n_pass++;
        xfer(1'b0, 5'h10, 2'd2, 32'd0, TMO, 1'b0);
        idle(5);
        xfer(1'b0, 5'h10, 2'd2, 32'd0, TMO, 1'b0);
        xfer(1'b0, 5'h14, 2'd2, 32'd0, 32'd0, 1'b0);
        xfer(1'b1, 5'h14, 2'd2, 32'd100, 32'd0, 1'b0);
        xfer(1'b0, 5'h14, 2'd2, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic test_wdog_zero();
        do_reset();
        arm();
        idle(2);
        n_checks++;
        if (timeout !== 1'b0)
            $display("FAIL wdog_zero_pre: got tmo=%b want 0", timeout);
        else
            n_pass++;
        xfer(1'b1, 5'h14, 2'd2, 32'd0, 32'd0, 1'b0);
        n_checks++;
        if ({done, timeout} !== 2'b11)
            $display("FAIL wdog_zero_tmo: got done=%b tmo=%b want 1 1", done, timeout);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        arm();
        // WDOG reaches 0 on the same edge as the exit write.
        xfer(1'b1, 5'h14, 2'd2, 32'd1, 32'd0, 1'b0);
        xfer(1'b1, 5'h00, 2'd2, 32'h0000_0001, 32'd0, 1'b0);
        idle(3);
        n_checks++;
        if ({done, pass, timeout, exit_code} !== {1'b1, 1'b1, 1'b0, 31'd0})
            $display("FAIL collision_status: got done=%b pass=%b tmo=%b code=%h want 1 1 0 0",
                     done, pass, timeout, exit_code);
        else
            n_pass++;
    endtask

    task automatic test_async_reset();
        // Start from an exited state with a transfer in flight.
        do_reset();
        arm();
        xfer(1'b1, 5'h00, 2'd2, 32'h0000_0009, 32'd0, 1'b0);
        tcb_vld = 1'b1;
        tcb_wen = 1'b1;
        tcb_adr = 5'h08;
        tcb_siz = 2'd2;
        tcb_wdt = 32'h0000_1234;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tcb_rdy, done, pass, timeout, exit_code, tcb_rdt, tcb_err} !== 68'd0)
            $display("FAIL async_reset_outputs: got rdy=%b done=%b pass=%b tmo=%b code=%h rdt=%h err=%b want all 0",
                     tcb_rdy, done, pass, timeout, exit_code, tcb_rdt, tcb_err);
        else
            n_pass++;
        tcb_vld = 1'b0;
        tcb_wen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 5'h14, 2'd2, 32'd0, TMO, 1'b0);
        xfer(1'b0, 5'h08, 2'd2, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_syscall();
        test_exit_pass();
        test_exit_fail();
        test_timeout();
        test_wdog_zero();
        test_back_to_back();
        test_async_reset();
        idle(2);
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL sb_drain: got %0d pending entries want 0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/r5p_tcb_htif.md
# r5p_tcb_htif

Synthesizable host-target interface (HTIF) peripheral that terminates one TCB port downstream of the r5p_mouse system bus decoder. Captures the RISCOF `tohost` exit write, holds signature bounds, counts cycles and enforces a watchdog timeout. It exposes `done`/`pass`/`exit_code` so FPGA builds and simulation benches end tests without a behavioural monitor.

## Interface
Parameters:
- `TIMEOUT`, 20000: watchdog reset value, in clock cycles after reset release.
- `ADR_W`, 5: decoded address bits used (word offsets 0x00–0x14).

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset; asynchronous and active-low.
- `tcb_vld` input 1: request valid.
- `tcb_wen` input 1: write enable.
- `tcb_adr` input ADR_W: byte address offset.
- `tcb_siz` input 2: log2 transfer size (0=byte, 1=half, 2=word).
- `tcb_wdt` input 32: write data, little endian.
- `tcb_rdt` output 32: read data.
- `tcb_err` output 1: response error.
- `tcb_rdy` output 1: request ready.
- `done` output 1: test finished (exit or timeout).
- `pass` output 1: exit code zero and no timeout.
- `exit_code` output 31: `tohost[31:1]` of the exit write.
- `timeout` output 1: watchdog expired.

## Operation
- Register map (word offsets): 0x00 TOHOST (W, reads 0); 0x04 FROMHOST (RW, 32 b); 0x08 SIG_BEGIN (RW); 0x0C SIG_END (RW); 0x10 CYCLE (RO, free-running counter); 0x14 WDOG (RW, remaining cycles).
- Transfer occurs when `tcb_vld & tcb_rdy`. `tcb_rdy` is 1 in every state after reset release; 0 during reset.
- Only word accesses (`siz==2`, `adr[1:0]==0`) to 0x00–0x14 are legal. Any other access: no register change, `tcb_err=1` in response, `tcb_rdt=0`. Writes to CYCLE are errors.
- State machine: RUN -> EXIT on a legal TOHOST write with `wdt[0]=1`; RUN -> TMO when WDOG reaches 0. EXIT and TMO are terminal until reset.
- TOHOST write with `wdt[0]=0` (syscall): copies `wdt` into FROMHOST as acknowledgement, state stays RUN.
- EXIT: `exit_code<=wdt[31:1]`, `done=1`, `pass=(wdt[31:1]==0)`.
- TMO: `timeout=1`, `done=1`, `pass=0`, `exit_code` unchanged (0).
- In EXIT/TMO: register reads still served; writes accepted (rdy=1, err=0) but ignored; CYCLE and WDOG frozen.
- CYCLE: +1 per clock in RUN, wraps 0xFFFF_FFFF -> 0.
- WDOG: reset value TIMEOUT; −1 per clock in RUN; a write loads `wdt`; writing 0 forces TMO next cycle. Write and decrement in the same cycle: write wins.
- Simultaneous TOHOST exit write and WDOG reaching 0 in the same cycle: EXIT wins, `timeout` stays 0.

## Timing
- Reset (rst_n low, asynchronous): state RUN; `tcb_rdt=0`, `tcb_err=0`, `tcb_rdy=0`, `done=0`, `pass=0`, `exit_code=0`, `timeout=0`; FROMHOST/SIG_BEGIN/SIG_END=0, CYCLE=0, WDOG=TIMEOUT.
- Response latency 1: `tcb_rdt`/`tcb_err` valid the cycle after the transfer, held until the next transfer's response; 0 after reset.
- Register writes visible to a read transferred in the next cycle (back-to-back write-read returns new value).
- `done`/`pass`/`exit_code`/`timeout` registered: asserted the cycle after the exit transfer or WDOG==0.
- Reset asserted mid-transfer: all outputs return to reset values immediately; transfer discarded.

## Test plan
- Exit pass: write 0x0000_0001 to 0x00 -> next cycle `done=1`, `pass=1`, `exit_code=0`; later writes to 0x00 ignored.
- Exit fail: write 0x0000_0007 to 0x00 -> `done=1`, `pass=0`, `exit_code=3`.
- Timeout: TIMEOUT=16, no accesses -> `timeout=1`, `done=1` exactly 16 cycles after reset release; CYCLE reads 16 thereafter.
- Register RW + errors: write 0x8000_2000 to 0x08, read next cycle -> 0x8000_2000, err=0; byte write to 0x08 and write to 0x10 -> err=1, values unchanged.
- Syscall/collision: write 0x0000_0100 to 0x00 -> FROMHOST reads 0x100, still RUN; set WDOG=1 and exit write same cycle -> EXIT, `timeout=0`.
- Async reset mid-run: drop rst_n between clock edges after an exit -> all outputs 0 immediately, WDOG reads TIMEOUT after release.
